apb_cmd_master: RTL and testbench

//   APB requester (initiator) that turns single-beat commands from a local controller into APB

---
 rtl/apb_cmd_master.sv | 142 ++++++++++++++
 tb/tb_apb_cmd_master.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_cmd_master.sv
// APB requester: turns single-beat local commands into APB SETUP/ACCESS
// transfers. It handles PREADY wait states and aborts a stalled ACCESS phase
// after TIMEOUT low-PREADY cycles. It returns exactly one response per command.
module apb_cmd_master #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              i_PCLK,
  input  logic              i_PRESET,
  input  logic              i_CMD_VALID,
  output logic              o_CMD_READY,
  input  logic              i_CMD_WRITE,
  input  logic [ADDR_W-1:0] i_CMD_ADDR,
  input  logic [DATA_W-1:0] i_CMD_WDATA,
  output logic              o_RSP_VALID,
  input  logic              i_RSP_READY,
  output logic [DATA_W-1:0] o_RSP_RDATA,
  output logic              o_RSP_ERR,
  output logic              o_BUSY,
  output logic              o_PSEL,
  output logic              o_PENABLE,
  output logic              o_PWRITE,
  output logic [ADDR_W-1:0] o_PADDR,
  output logic [DATA_W-1:0] o_PWDATA,
  input  logic              i_PREADY,
  input  logic [DATA_W-1:0] i_PRDATA
);

  // Wide enough to hold TIMEOUT; one bit when the timeout is disabled.
  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t            state;
  state_t            next_state;
  logic [CNT_W-1:0]  wait_cnt;
  logic              accept;
  logic              timeout_hit;

  logic              cmd_ready_d;
  logic              busy_d;
  logic              psel_d;
  logic              penable_d;
  logic              rsp_valid_d;
  logic              pwrite_d;
  logic [ADDR_W-1:0] paddr_d;
  logic [DATA_W-1:0] pwdata_d;
  logic [DATA_W-1:0] rdata_d;
  logic              err_d;

  // Wait counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // o_CMD_READY is low for the first cycle after reset, so it gates acceptance.
  assign accept      = i_CMD_VALID & o_CMD_READY;
  // This low-PREADY edge would bring the count up to TIMEOUT.
  assign timeout_hit = (TIMEOUT != 0) && ((32'(wait_cnt) + 32'd1) >= TIMEOUT);

  // State register.
  always_ff @(posedge i_PCLK or posedge i_PRESET) begin
    if (i_PRESET) state <= IDLE;
    else          state <= next_state;
  end

  // Next-state decode; PREADY is checked before the timeout, so a completion wins.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (accept) next_state = SETUP;
      SETUP:   next_state = ACCESS;
      ACCESS:  if (i_PREADY || timeout_hit) next_state = RESP;
      RESP:    if (i_RSP_READY) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Counts low-PREADY edges in ACCESS; cleared while in SETUP so each transfer starts at 0.
  always_ff @(posedge i_PCLK or posedge i_PRESET) begin
    if (i_PRESET)                      wait_cnt <= '0;
    else if (state == SETUP)           wait_cnt <= '0;
    else if (state == ACCESS && !i_PREADY) wait_cnt <= sat_inc(wait_cnt);
  end

  // Output decode from the next state, so every registered output lines up with its state.
  always_comb begin
    cmd_ready_d = (next_state == IDLE);
    busy_d      = (next_state != IDLE);
    psel_d      = (next_state == SETUP) || (next_state == ACCESS);
    penable_d   = (next_state == ACCESS);
    rsp_valid_d = (next_state == RESP);
    pwrite_d    = o_PWRITE;
    paddr_d     = o_PADDR;
    pwdata_d    = o_PWDATA;
    rdata_d     = o_RSP_RDATA;
    err_d       = o_RSP_ERR;
    if (accept) begin
      pwrite_d = i_CMD_WRITE;
      paddr_d  = i_CMD_ADDR;
      pwdata_d = i_CMD_WRITE ? i_CMD_WDATA : '0;
    end
    if (state == ACCESS) begin
      if (i_PREADY) begin
        rdata_d = o_PWRITE ? '0 : i_PRDATA;
        err_d   = 1'b0;
      end else if (timeout_hit) begin
        rdata_d = '0;
        err_d   = 1'b1;
      end
    end
  end

  // Output registers. Reset clears them at once, which also drops an in-flight transfer.
  always_ff @(posedge i_PCLK or posedge i_PRESET) begin
    if (i_PRESET) begin
      o_CMD_READY <= 1'b0;
      o_BUSY      <= 1'b0;
      o_PSEL      <= 1'b0;
      o_PENABLE   <= 1'b0;
      o_RSP_VALID <= 1'b0;
      o_PWRITE    <= 1'b0;
      o_PADDR     <= '0;
      o_PWDATA    <= '0;
      o_RSP_RDATA <= '0;
      o_RSP_ERR   <= 1'b0;
    end else begin
      o_CMD_READY <= cmd_ready_d;
      o_BUSY      <= busy_d;
      o_PSEL      <= psel_d;
      o_PENABLE   <= penable_d;
      o_RSP_VALID <= rsp_valid_d;
      o_PWRITE    <= pwrite_d;
      o_PADDR     <= paddr_d;
      o_PWDATA    <= pwdata_d;
      o_RSP_RDATA <= rdata_d;
      o_RSP_ERR   <= err_d;
    end
  end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Testbench for apb_cmd_master: transaction-level reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_apb_cmd_master;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [15:0] cmd_addr = '0;
  logic [7:0]  cmd_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic        busy;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [15:0] paddr;
  logic [7:0]  pwdata;
  logic        pready = 1'b0;
  logic [7:0]  prdata = '0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int wait_k = 0;

  // Reference model: one outstanding command, its age in cycles and its outcome.
  bit          m_busy, m_done, m_rdy, m_wr, m_err;
  int          m_age, m_low;
  logic [15:0] m_addr;
  logic [7:0]  m_wdata, m_rdata;

  apb_cmd_master #(.ADDR_W(16), .DATA_W(8), .TIMEOUT(TO)) dut (
    .i_PCLK(clk), .i_PRESET(rst),
    .i_CMD_VALID(cmd_valid), .o_CMD_READY(cmd_ready), .i_CMD_WRITE(cmd_write),
    .i_CMD_ADDR(cmd_addr), .i_CMD_WDATA(cmd_wdata),
    .o_RSP_VALID(rsp_valid), .i_RSP_READY(rsp_ready), .o_RSP_RDATA(rsp_rdata),
    .o_RSP_ERR(rsp_err), .o_BUSY(busy),
    .o_PSEL(psel), .o_PENABLE(penable), .o_PWRITE(pwrite), .o_PADDR(paddr),
    .o_PWDATA(pwdata), .i_PREADY(pready), .i_PRDATA(prdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Completer: PREADY goes high in the (wait_k+1)-th ACCESS cycle.
  initial begin
    int acc;
    acc = 0;
    forever begin
      @(negedge clk);
      if (penable) acc++;
      else acc = 0;
      pready = (acc > wait_k);
    end
  end

  // Model update on each clock edge, from the inputs set up before that edge.
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_busy = 0; m_done = 0; m_rdy = 0; m_age = 0; m_low = 0;
    end else if (!m_busy) begin
      if (m_rdy && cmd_valid) begin
        m_busy = 1; m_done = 0; m_age = 1; m_low = 0; m_rdy = 0;
        m_wr = cmd_write; m_addr = cmd_addr; m_wdata = cmd_wdata;
      end else begin
        m_rdy = 1;
      end
    end else if (!m_done) begin
      if (m_age >= 2) begin
        if (pready) begin
          m_done = 1; m_err = 0; m_rdata = m_wr ? 8'h00 : prdata;
        end else begin
          m_low++;
          if (TO != 0 && m_low >= TO) begin
            m_done = 1; m_err = 1; m_rdata = 8'h00;
          end
        end
      end
      m_age++;
    end else if (rsp_ready) begin
      m_busy = 0; m_done = 0; m_rdy = 1;
    end
  end

  // Per-cycle comparison of the DUT against the model.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      chk("rst_psel", psel, 0);
      chk("rst_penable", penable, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_cmd_ready", cmd_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_paddr", paddr, 0);
    end else begin
      chk("cmd_ready", cmd_ready, m_rdy);
      chk("busy", busy, m_busy);
      chk("psel", psel, m_busy && !m_done);
      chk("penable", penable, m_busy && !m_done && m_age >= 2);
      chk("rsp_valid", rsp_valid, m_busy && m_done);
      if (m_busy && !m_done) begin
        chk("paddr", paddr, m_addr);
        chk("pwrite", pwrite, m_wr);
        chk("pwdata", pwdata, m_wr ? m_wdata : 8'h00);
      end
      if (m_busy && m_done) begin
        chk("rsp_rdata", rsp_rdata, m_rdata);
        chk("rsp_err", rsp_err, m_err);
      end
    end
  end

  // Presents a command and returns at the negedge just after it is accepted.
  task automatic send(input bit wr, input logic [15:0] a, input logic [7:0] d);
    int n;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("send_accept", (n < 50), 1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Watches one transfer from SETUP until its response is consumed.
  task automatic observe(output int np, output int ne, output int ri, output logic [7:0] rd,
                         output logic er, output bit stable);
    logic [15:0] a0;
    bit have_a, fin;
    np = 0; ne = 0; ri = -1; rd = '0; er = 1'b0; stable = 1; have_a = 0; fin = 0; a0 = '0;
    for (int i = 0; i < 40 && !fin; i++) begin
      if (psel) begin
        np++;
        if (!have_a) begin a0 = paddr; have_a = 1; end
        else if (paddr !== a0) stable = 0;
      end
      if (penable) ne++;
      if (rsp_valid && ri < 0) begin ri = i; rd = rsp_rdata; er = rsp_err; end
      if (rsp_valid && rsp_ready) fin = 1;
      @(negedge clk);
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: run exceeded time limit at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int np, ne, ri, held, stale, n_acc, n_rise, gap, min_gap;
    logic [7:0] rd;
    logic er;
    bit st, found, adv, prev_psel;
    logic [15:0] addrs[3];
    logic [7:0]  datas[3];
    logic [15:0] rise_addr[3];
    int          acc_t[3];

    // Reset state, then release.
    repeat (3) @(negedge clk);
    chk("init_cmd_ready", cmd_ready, 0);
    chk("init_busy", busy, 0);
    chk("init_psel", psel, 0);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("rel_cmd_ready", cmd_ready, 1);

    // 1: write 0x0040 = 0x12, no wait states.
    wait_k = 0; rsp_ready = 1;
    send(1, 16'h0040, 8'h12);
    chk("t1_paddr", paddr, 16'h0040);
    chk("t1_pwrite", pwrite, 1);
    chk("t1_pwdata", pwdata, 8'h12);
    observe(np, ne, ri, rd, er, st);
    chk("t1_psel_cycles", np, 2);
    chk("t1_penable_cycles", ne, 1);
    chk("t1_rsp_index", ri, 2);
    chk("t1_rdata", rd, 8'h00);
    chk("t1_err", er, 0);

    // 2: read 0x0044 with 3 wait states, PRDATA = 0xA5.
    wait_k = 3; prdata = 8'hA5;
    send(0, 16'h0044, 8'hFF);
    chk("t2_pwdata_read", pwdata, 8'h00);
    observe(np, ne, ri, rd, er, st);
    chk("t2_penable_cycles", ne, 4);
    chk("t2_psel_cycles", np, 5);
    chk("t2_addr_stable", st, 1);
    chk("t2_rdata", rd, 8'hA5);
    chk("t2_err", er, 0);

    // 3: PREADY stuck low -> abort after 8 ACCESS cycles, then a normal write.
    wait_k = 1000; prdata = 8'h5E;
    send(0, 16'h0044, 8'h00);
    observe(np, ne, ri, rd, er, st);
    chk("t3_penable_cycles", ne, 8);
    chk("t3_psel_cycles", np, 9);
    chk("t3_err", er, 1);
    chk("t3_rdata", rd, 8'h00);
    wait_k = 0;
    send(1, 16'h004C, 8'h5A);
    observe(np, ne, ri, rd, er, st);
    chk("t3_next_penable", ne, 1);
    chk("t3_next_err", er, 0);

    // 4: response held while RSP_READY stays low for 5 cycles.
    rsp_ready = 0; wait_k = 0; prdata = 8'h3C;
    send(0, 16'h0044, 8'h00);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (rsp_valid) found = 1;
      else @(negedge clk);
    end
    chk("t4_rsp_seen", found, 1);
    cmd_valid = 1; cmd_write = 1; cmd_addr = 16'h0040; cmd_wdata = 8'h77;
    held = 0;
    for (int i = 0; i < 5; i++) begin
      if (rsp_valid && rsp_rdata == 8'h3C && !rsp_err && !cmd_ready && !psel) held++;
      @(negedge clk);
    end
    chk("t4_held_cycles", held, 5);
    rsp_ready = 1; cmd_valid = 0;
    @(negedge clk);
    chk("t4_idle_ready", cmd_ready, 1);
    chk("t4_idle_rsp", rsp_valid, 0);

    // 5: three back-to-back writes with CMD_VALID held high.
    addrs = '{16'h0040, 16'h0044, 16'h004C};
    datas = '{8'h11, 8'h22, 8'h33};
    n_acc = 0; adv = 0; prev_psel = 0; n_rise = 0; gap = 0; min_gap = 99;
    acc_t = '{0, 0, 0};
    rise_addr = '{16'h0, 16'h0, 16'h0};
    cmd_valid = 1; cmd_write = 1; cmd_addr = addrs[0]; cmd_wdata = datas[0];
    for (int i = 0; i < 20; i++) begin
      if (adv) begin
        adv = 0;
        if (n_acc < 3) begin cmd_addr = addrs[n_acc]; cmd_wdata = datas[n_acc]; end
        else cmd_valid = 0;
      end
      if (psel) begin
        if (!prev_psel) begin
          if (n_rise < 3) rise_addr[n_rise] = paddr;
          if (n_rise > 0 && gap < min_gap) min_gap = gap;
          n_rise++;
        end
        gap = 0;
      end else begin
        gap++;
      end
      prev_psel = psel;
      if (cmd_valid && cmd_ready) begin
        if (n_acc < 3) acc_t[n_acc] = cyc;
        n_acc++;
        adv = 1;
      end
      @(negedge clk);
    end
    chk("t5_accepts", n_acc, 3);
    chk("t5_transfers", n_rise, 3);
    chk("t5_spacing_1", acc_t[1] - acc_t[0], 4);
    chk("t5_spacing_2", acc_t[2] - acc_t[1], 4);
    chk("t5_addr_0", rise_addr[0], 16'h0040);
    chk("t5_addr_1", rise_addr[1], 16'h0044);
    chk("t5_addr_2", rise_addr[2], 16'h004C);
    chk("t5_psel_gap", min_gap, 2);

    // 6: reset asserted during ACCESS.
    wait_k = 1000; rsp_ready = 1;
    send(0, 16'h004C, 8'h00);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (penable) found = 1;
      else @(negedge clk);
    end
    chk("t6_access_seen", found, 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_psel_now", psel, 0);
    chk("t6_penable_now", penable, 0);
    chk("t6_rsp_valid_now", rsp_valid, 0);
    chk("t6_busy_now", busy, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("t6_ready_before_clk", cmd_ready, 0);
    wait_k = 0;
    @(negedge clk);
    chk("t6_ready_after_clk", cmd_ready, 1);
    stale = 0;
    for (int i = 0; i < 8; i++) begin
      if (rsp_valid) stale++;
      @(negedge clk);
    end
    chk("t6_no_stale_rsp", stale, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
